// File: rtl/nwc_pkg.sv
// Shared NWC datapath types, constants and modular add/sub helpers.
// Reused by the CT post-stage and the GS-stage pre-adder.
`ifndef D_width
`define D_width 16
`endif

package nwc_pkg;

   localparam int unsigned D_W          = `D_width;
   localparam int unsigned BF_EXTRA_LAT = 2;

   typedef logic [D_W-1:0] data_t;

   typedef struct packed {
      data_t x;
      data_t y;
   } bf_pair_t;

   typedef struct packed {
      logic  v;
      data_t a;
   } a_tag_t;

   // (a + b) mod q for a, b < q
   function automatic data_t mod_add(input data_t a, input data_t b, input data_t q);
      logic [D_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= {1'b0, q}) begin
         sum = sum - {1'b0, q};
      end
      return D_W'(sum);
   endfunction

   // (a - b) mod q for a, b < q; the extra top bit acts as the sign
   function automatic data_t mod_sub(input data_t a, input data_t b, input data_t q);
      logic [D_W:0] diff;
      diff = {1'b0, a} - {1'b0, b};
      if (diff[D_W]) begin
         diff = diff + {1'b0, q};
      end
      return D_W'(diff);
   endfunction

endpackage

// File: rtl/nwc_sync_fifo.sv
// Single-clock FIFO with registered head data, registered valid and occupancy count.
module nwc_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_req,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] count_nxt;
   logic [WIDTH-1:0] rd_data_nxt;
   logic             full;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CNT_W'(DEPTH));
   assign rd_en = pop_req && rd_valid;
   assign wr_en = push && (!full || rd_en);

   always_comb begin
      count_nxt = count;
      if (wr_en && !rd_en) begin
         count_nxt = count + CNT_W'(1);
      end else if (rd_en && !wr_en) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   // Head register always mirrors mem[rd_ptr]; bypass the write when it lands at the head
   always_comb begin
      rd_data_nxt = rd_data;
      if (wr_en && ((count == '0) || (rd_en && count == CNT_W'(1)))) begin
         rd_data_nxt = push_data;
      end else if (rd_en && count > CNT_W'(1)) begin
         rd_data_nxt = mem[rd_ptr + AW'(1)];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         count    <= count_nxt;
         rd_valid <= (count_nxt != '0);
         rd_data  <= rd_data_nxt;
      end
   end

endmodule

// File: rtl/nwc_butterfly_post.sv
// CT butterfly after the modular multiplier: aligns A with W*B, forms A+WB / A-WB mod q,
// buffers results in a FIFO and throttles launches with a credit count.
`ifndef D_width
`define D_width 16
`endif

module nwc_butterfly_post
   import nwc_pkg::*;
#(
   parameter int unsigned MUL_LAT    = 3,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 launch_valid,
   input  logic [`D_width-1:0]  a_in,
   input  logic [`D_width-1:0]  wb_in,
   input  logic [`D_width-1:0]  modulus,
   output logic                 launch_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [`D_width-1:0]  x_out,
   output logic [`D_width-1:0]  y_out,
   output logic                 ovf_err
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned INF_W = $clog2(FIFO_DEPTH + MUL_LAT + BF_EXTRA_LAT);
   localparam int unsigned SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

   a_tag_t           dly [MUL_LAT];
   logic             al_v;
   data_t            al_a;
   data_t            al_wb;
   logic             bf_v;
   bf_pair_t         bf_q;
   bf_pair_t         head;
   logic [CNT_W-1:0] fifo_count;
   logic [INF_W-1:0] inflight;
   logic             launch_ok;

   // Every accepted launch holds a FIFO slot until popped, so overflow cannot happen
   assign launch_ready = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);
   assign launch_ok    = launch_valid && launch_ready;

   // A delay line; a refused launch enters with its valid bit cleared so its product is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(MUL_LAT); i++) begin
            dly[i] <= '0;
         end
      end else begin
         dly[0] <= '{v: launch_ok, a: a_in};
         for (int i = 1; i < int'(MUL_LAT); i++) begin
            dly[i] <= dly[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         al_v  <= 1'b0;
         al_a  <= '0;
         al_wb <= '0;
         bf_v  <= 1'b0;
         bf_q  <= '0;
      end else begin
         al_v  <= dly[MUL_LAT-1].v;
         al_a  <= dly[MUL_LAT-1].a;
         al_wb <= wb_in;
         bf_v  <= al_v;
         bf_q  <= '{x: mod_add(al_a, al_wb, modulus), y: mod_sub(al_a, al_wb, modulus)};
      end
   end

   // Credits held from launch acceptance until the FIFO push
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= '0;
      end else if (launch_ok && !bf_v) begin
         inflight <= inflight + INF_W'(1);
      end else if (!launch_ok && bf_v) begin
         inflight <= inflight - INF_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_err <= 1'b0;
      end else if (launch_valid && !launch_ready) begin
         ovf_err <= 1'b1;
      end
   end

   nwc_sync_fifo #(
      .WIDTH ($bits(bf_pair_t)),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bf_v),
      .push_data (bf_q),
      .pop_req   (out_ready),
      .rd_valid  (out_valid),
      .rd_data   (head),
      .count     (fifo_count)
   );

   assign x_out = head.x;
   assign y_out = head.y;

endmodule

// File: tb/tb_nwc_butterfly_post.sv
// Randomized bench for nwc_butterfly_post against a transaction-level reference model.
module tb_nwc_butterfly_post;
   import nwc_pkg::*;

   localparam int L     = 3;
   localparam int DEPTH = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           launch_valid;
   logic [D_W-1:0] a_in;
   logic [D_W-1:0] wb_in;
   logic [D_W-1:0] modulus;
   logic           launch_ready;
   logic           out_valid;
   logic           out_ready;
   logic [D_W-1:0] x_out;
   logic [D_W-1:0] y_out;
   logic           ovf_err;

   nwc_butterfly_post #(.MUL_LAT(L), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .launch_valid (launch_valid),
      .a_in         (a_in),
      .wb_in        (wb_in),
      .modulus      (modulus),
      .launch_ready (launch_ready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .x_out        (x_out),
      .y_out        (y_out),
      .ovf_err      (ovf_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      int push_edge;
   } res_t;

   res_t exp_q[$];
   int   wb_line[$];
   int   total   = 0;
   int   bad     = 0;
   int   edge_now = 0;
   int   n_acc   = 0;
   int   n_pop   = 0;
   int   hs_cnt  = 0;
   int   qmod    = 17;
   bit   ovf_exp = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: drive, check against the model at negedge, advance the model, cross the edge
   task automatic step(input bit lv, input int a, input int wb, input bit ordy);
      bit rdy_exp;
      bit vld_exp;
      launch_valid = lv;
      a_in         = D_W'(a);
      wb_in        = D_W'(wb_line.pop_front());
      wb_line.push_back(wb);
      out_ready    = ordy;
      @(negedge clk);
      rdy_exp = (n_acc - n_pop) < DEPTH;
      vld_exp = (exp_q.size() > 0) && (exp_q[0].push_edge <= edge_now);
      chk("launch_ready", int'(launch_ready), int'(rdy_exp));
      chk("out_valid", int'(out_valid), int'(vld_exp));
      chk("ovf_err", int'(ovf_err), int'(ovf_exp));
      if (vld_exp) begin
         chk("x_out", int'(x_out), exp_q[0].x);
         chk("y_out", int'(y_out), exp_q[0].y);
      end
      if (out_valid && ordy) hs_cnt++;
      if (ordy && vld_exp) begin
         void'(exp_q.pop_front());
         n_pop++;
      end
      if (lv && rdy_exp) begin
         exp_q.push_back('{(a + wb) % qmod, (a - wb + qmod) % qmod, edge_now + 1 + L + 2});
         n_acc++;
      end else if (lv) begin
         ovf_exp = 1'b1;
      end
      @(posedge clk);
      edge_now++;
      #1;
   endtask

   task automatic reset_model();
      exp_q.delete();
      wb_line.delete();
      for (int i = 0; i < L; i++) wb_line.push_back(0);
      n_acc   = 0;
      n_pop   = 0;
      ovf_exp = 1'b0;
   endtask

   function automatic int rnd();
      return int'($urandom_range(qmod - 1));
   endfunction

   initial begin
      int k;
      int lat;
      int acc;
      int hs0;
      bit lr;
      modulus      = D_W'(17);
      launch_valid = 1'b0;
      a_in         = '0;
      wb_in        = '0;
      out_ready    = 1'b0;
      reset_model();
      #1 rst = 1'b1;
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_x_out", int'(x_out), 0);
      chk("rst_y_out", int'(y_out), 0);
      chk("rst_ovf_err", int'(ovf_err), 0);
      chk("rst_launch_ready", int'(launch_ready), 1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      edge_now = 0;

      // single launch: latency and value
      step(1'b1, 5, 15, 1'b1);
      k   = edge_now;
      lat = -1;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 0, 0, 1'b1);
         if (lat < 0 && out_valid) begin
            lat = edge_now - k;
            chk("single_x", int'(x_out), 3);
            chk("single_y", int'(y_out), 7);
         end
      end
      chk("single_latency", lat, L + 2);

      // boundary operands
      step(1'b1, 16, 16, 1'b1);
      step(1'b1, 0, 16, 1'b1);
      step(1'b1, 0, 0, 1'b1);
      repeat (10) step(1'b0, 0, 0, 1'b1);

      // streaming with a realistic modulus
      modulus = D_W'(12289);
      qmod    = 12289;
      for (int i = 0; i < 20; i++) step(1'b1, rnd(), rnd(), 1'b1);
      repeat (10) step(1'b0, 0, 0, 1'b1);

      // backpressure: launches gated by launch_ready until the credits run out
      acc = 0;
      for (int i = 0; i < 16; i++) begin
         lr = launch_ready;
         if (lr) acc++;
         step(lr, rnd(), rnd(), 1'b0);
      end
      chk("accepted_until_full", acc, DEPTH);

      // protocol violation while full, then drain
      step(1'b1, rnd(), rnd(), 1'b0);
      repeat (3) step(1'b0, 0, 0, 1'b0);
      hs0 = hs_cnt;
      repeat (20) step(1'b0, 0, 0, 1'b1);
      chk("drain_count", hs_cnt - hs0, DEPTH);

      // reset with 2 results in the FIFO and 3 still in flight
      for (int i = 0; i < 5; i++) step(1'b1, rnd(), rnd(), 1'b0);
      repeat (2) step(1'b0, 0, 0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_x_out", int'(x_out), 0);
      chk("midrst_y_out", int'(y_out), 0);
      chk("midrst_ovf_err", int'(ovf_err), 0);
      chk("midrst_launch_ready", int'(launch_ready), 1);
      reset_model();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (12) step(1'b0, 0, 0, 1'b1);
      step(1'b1, 100, 12288, 1'b1);
      repeat (10) step(1'b0, 0, 0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nwc_butterfly_post.md
# nwc_butterfly_post

Downstream companion stage of the modular multiplier in the NWC datapath. It receives the reduced product W·B from the multiplier, aligns it with the untouched upper operand A launched in the same cycle, and forms the Cooley-Tukey butterfly outputs X = (A + WB) mod q and Y = (A − WB) mod q. Results are buffered in a small output FIFO with valid/ready handshaking. A credit-based `launch_ready` lets the non-stallable multiplier pipeline be throttled at its input.

## Interface
- `MUL_LAT`, default 3: fixed latency of the multiplier, in clock edges from operand launch to valid result.
- `FIFO_DEPTH`, default 8: output buffer entries; must be a power of two and ≥ 2.
- Data width is the codebase-wide `` `D_width `` macro.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `launch_valid`  in  1  an (A, B) pair is entering the multiplier this cycle.
- `a_in`  in  `` `D_width ``  upper butterfly operand, presented together with `launch_valid`.
- `wb_in`  in  `` `D_width ``  multiplier result; valid exactly `MUL_LAT` edges after its launch.
- `modulus`  in  `` `D_width ``  q; quasi-static, changed only while the block is idle.
- `launch_ready`  out  1  upstream may assert `launch_valid` only while this is high.
- `out_valid`  out  1  FIFO head holds a result.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `x_out`  out  `` `D_width ``  (A + WB) mod q.
- `y_out`  out  `` `D_width ``  (A − WB) mod q.
- `ovf_err`  out  1  sticky; set by a launch attempted while `launch_ready` is low.

## Operation
- **A delay line.** `MUL_LAT`-deep shift register of {valid, A}, so that A and its valid bit arrive at the butterfly in the same cycle as the matching `wb_in`.
- **Butterfly.** Operates on the delayed A and `wb_in`. Both are < q.
  - Sum computed at `` `D_width+1 `` bits; if sum ≥ q, subtract q.
  - Difference computed at `` `D_width+1 `` bits; if it is negative, add q.
  - Both results are registered, then pushed into the FIFO.
- **Credit tracking.** `inflight` counter, `$clog2(FIFO_DEPTH+MUL_LAT+2)` bits.
  - Increments on an accepted launch.
  - Decrements on a FIFO push.
  - Increment and decrement in the same cycle leave it unchanged.
- **launch_ready** = (`fifo_count` + `inflight`) < `FIFO_DEPTH`, decoded combinationally from registers. A FIFO overflow is therefore impossible by construction.
- **Launch while not ready.**
  - The launch is not accepted and `inflight` is unchanged.
  - `ovf_err` is set and stays set until reset.
  - The already-launched multiplier product for that launch is discarded: its delayed valid bit is forced to 0.
- **FIFO.** A pop occurs when `out_valid && out_ready`. Simultaneous push and pop in the same cycle keeps the count. `out_ready` while empty has no effect.
- **Reset, including mid-operation.** Clears the delay line, `inflight`, FIFO pointers and count, and `ovf_err`. All in-flight data is lost.
- **Reset values.** `out_valid`=0, `x_out`=0, `y_out`=0, `ovf_err`=0, `launch_ready`=1.

## Timing
- Launch sampled at edge k → `wb_in` sampled at edge k+`MUL_LAT` → butterfly register loaded at edge k+`MUL_LAT`+1.
- The FIFO push occurs at edge k+`MUL_LAT`+2.
- If the FIFO is empty, `out_valid` rises after that edge: total latency `MUL_LAT`+2 edges.
- Throughput is one butterfly per cycle while `out_ready` is held high.
- `inflight` counts every accepted launch until its push edge.
- `launch_ready` can drop in the same cycle a launch is accepted. Upstream must sample it before launching.
- `x_out` / `y_out` reflect the FIFO head and are held stable while `out_valid && !out_ready`.

## Structure
- **Shared package `nwc_pkg`** holds:
  - the functions `mod_add(a, b, q)` and `mod_sub(a, b, q)`, widths derived from `` `D_width ``, for reuse by the GS-stage pre-adder;
  - the constant `BF_EXTRA_LAT = 2` (butterfly register + FIFO write).
- **Sub-module `nwc_sync_fifo`**: parameterised width/depth, count output, registered read data.
  - Instantiated here with width 2·`` `D_width ``, carrying {X, Y}.
- The delay line, butterfly and credit logic live in the top module.

## Test plan
- **Single launch.** q=17, a=5, wb=15, `MUL_LAT`=3 → x=3, y=7; `out_valid` rises exactly 5 edges after the launch.
- **Boundary operands.** q=17, a=16, wb=16 → x=15, y=0. Then a=0, wb=16 → x=16, y=1. Then a=0, wb=0 → x=0, y=0.
- **Streaming.** 20 back-to-back launches with `out_ready`=1 and random a, wb < q=12289 → 20 results in order, matching the reference model, no gaps after the first.
- **Backpressure.** `out_ready`=0 with continuous launch attempts gated by `launch_ready`:
  - `launch_ready` falls after exactly `FIFO_DEPTH` accepted launches;
  - releasing `out_ready` drains 8 results in order and re-raises `launch_ready`.
- **Protocol violation.** Launch while `launch_ready`=0 → `ovf_err`=1 and sticky, result count unchanged, no FIFO corruption.
- **Reset mid-stream.** Assert `rst` with 3 results in flight and 2 in the FIFO → all outputs at their reset values immediately (asynchronous); after release, no stale results appear and `launch_ready`=1.
